// File: rtl/data_mem_responder_if.sv
// ----------------------------------------------------------------------------
// data_mem_responder_if
//   Memory-stage data bus between the pipeline (master) and a multi-cycle
//   data memory responder (slave).
//
//   Signals
//     addr      master -> slave  16  byte address; word index is addr[AW:1]
//     data_in   master -> slave  16  write data
//     rd        master -> slave   1  read request
//     wr        master -> slave   1  write request
//     data_out  slave -> master  16  read data, non-zero only in the done cycle
//     done      slave -> master   1  one-cycle completion pulse
//     stall     slave -> master   1  hold the request and freeze the pipeline
//     err       slave -> master   1  one-cycle pulse after an illegal request
// ----------------------------------------------------------------------------
interface data_mem_responder_if;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        rd;
    logic        wr;
    logic [15:0] data_out;
    logic        done;
    logic        stall;
    logic        err;

    modport master (
        output addr, data_in, rd, wr,
        input  data_out, done, stall, err
    );

    modport slave (
        input  addr, data_in, rd, wr,
        output data_out, done, stall, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//   Responder end of the memory-stage data interface. Accepts one read or
//   write request, stalls the requester for LAT cycles in total (counting the
//   acceptance cycle), then pulses done for one cycle with read data.
//
//   Parameters
//     AW   word-address width; storage is 2**AW words of 16 bits
//     LAT  cycles from request acceptance to done, 1..15
//
//   Ports
//     clk  clock, rising edge
//     rst  synchronous active-low reset
//     bus  data_mem_responder_if.slave (addr, data_in, rd, wr in;
//          data_out, done, stall, err out)
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting; a legal request is accepted in this cycle
//   BUSY   | latency countdown on the captured request
//   DONE   | one-cycle completion; done=1, data_out valid for a read
//   BAD    | unreachable encoding; flags err and recovers to IDLE
// ----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int AW  = 8,
    parameter int LAT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    data_mem_responder_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10,
        ST_BAD  = 2'b11
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            op_wr_q, op_wr_d;
    logic            err_q, err_d;
    logic [15:0]     dout_q;

    logic [15:0]     mem_q [2**AW];

    logic            req;
    logic            legal;
    logic            illegal;
    logic            stall;

    // Storage access performed on the edge that enters DONE. With LAT=1 that
    // edge is also the acceptance edge, so the live inputs are used instead
    // of the (not yet loaded) capture registers.
    logic            commit;
    logic [AW-1:0]   c_idx;
    logic [15:0]     c_data;
    logic            c_wr;

    assign req     = bus.rd | bus.wr;
    assign legal   = req & ~(bus.rd & bus.wr) & ~bus.addr[0];
    assign illegal = req & ((bus.rd & bus.wr) | bus.addr[0]);

    generate
        if (AW < 15) begin : g_unused_addr
            logic unused_addr_hi;
            assign unused_addr_hi = ^bus.addr[15:AW+1];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        op_wr_d = op_wr_q;
        err_d   = 1'b0;
        stall   = 1'b0;
        commit  = 1'b0;
        c_idx   = idx_q;
        c_data  = wdata_q;
        c_wr    = op_wr_q;

        case (state_q)
            ST_IDLE: begin
                if (legal) begin
                    stall   = 1'b1;
                    idx_d   = bus.addr[AW:1];
                    wdata_d = bus.data_in;
                    op_wr_d = bus.wr;
                    cnt_d   = CNT_LOAD;
                    if (LAT == 1) begin
                        state_d = ST_DONE;
                        commit  = 1'b1;
                        c_idx   = bus.addr[AW:1];
                        c_data  = bus.data_in;
                        c_wr    = bus.wr;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end else if (illegal) begin
                    err_d = 1'b1;
                end
            end

            ST_BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q - 4'd1;
                // <= 1 rather than == 1 so a corrupted zero count cannot
                // wrap into a 16-cycle hang.
                if (cnt_q <= 4'd1) begin
                    state_d = ST_DONE;
                    commit  = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            op_wr_q <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            op_wr_q <= op_wr_d;
            err_q   <= err_d;
            if (commit && !c_wr) begin
                dout_q <= mem_q[c_idx];
            end else begin
                dout_q <= '0;
            end
        end
    end

    // Storage is deliberately not cleared by reset; a reset that lands on
    // the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (rst && commit && c_wr) begin
            mem_q[c_idx] <= c_data;
        end
    end

    assign bus.stall    = stall;
    assign bus.done     = (state_q == ST_DONE);
    assign bus.err      = err_q;
    assign bus.data_out = dout_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    data_mem_responder_if if3 ();
    data_mem_responder_if if1 ();

    data_mem_responder #(.AW(8), .LAT(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3.slave)
    );

    data_mem_responder #(.AW(8), .LAT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    logic [15:0] t_addr [2];
    logic [15:0] t_din  [2];
    logic        t_rd   [2];
    logic        t_wr   [2];

    assign if3.addr    = t_addr[0];
    assign if3.data_in = t_din[0];
    assign if3.rd      = t_rd[0];
    assign if3.wr      = t_wr[0];
    assign if1.addr    = t_addr[1];
    assign if1.data_in = t_din[1];
    assign if1.rd      = t_rd[1];
    assign if1.wr      = t_wr[1];

    // Reference storage: one 256-word image per instance (AW=8).
    logic [15:0] m [2][256];

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
        t_rd[sel]   = r;
        t_wr[sel]   = w;
        t_addr[sel] = a;
        t_din[sel]  = d;
    endtask

    task automatic sample(input int sel, output logic [15:0] dout,
                          output logic done, output logic stall, output logic err);
        if (sel == 0) begin
            dout = if3.data_out; done = if3.done; stall = if3.stall; err = if3.err;
        end else begin
            dout = if1.data_out; done = if1.done; stall = if1.stall; err = if1.err;
        end
    endtask

    task automatic check_all(input int sel, input string tag, input logic [15:0] e_dout,
                             input logic e_done, input logic e_stall, input logic e_err);
        logic [15:0] dout;
        logic        done, stall, err;
        sample(sel, dout, done, stall, err);
        check({tag, ".data_out"}, dout, e_dout);
        check({tag, ".done"},     {15'd0, done},  {15'd0, e_done});
        check({tag, ".stall"},    {15'd0, stall}, {15'd0, e_stall});
        check({tag, ".err"},      {15'd0, err},   {15'd0, e_err});
    endtask

    // Called just after a rising edge. A legal request is left driven when
    // the task returns (the requester still holds it through done); the
    // next call replaces it in the following IDLE cycle.
    task automatic req(input int sel, input logic r, input logic w,
                       input logic [15:0] a, input logic [15:0] d, input bit scramble);
        int       lat;
        int       idx;
        bit       legal, illegal;
        lat     = (sel == 0) ? 3 : 1;
        idx     = int'(a[8:1]);
        legal   = (r | w) && !(r && w) && !a[0];
        illegal = (r | w) && ((r && w) || a[0]);
        drive(sel, r, w, a, d);
        if (legal) begin
            for (int k = 0; k < lat; k++) begin
                @(negedge clk);
                check_all(sel, "stall_phase", 16'h0, 1'b0, 1'b1, 1'b0);
                @(posedge clk); #1;
                if (scramble && k < lat - 1)
                    drive(sel, r, w, 16'($urandom), 16'($urandom));
            end
            @(negedge clk);
            check_all(sel, "done_phase", r ? m[sel][idx] : 16'h0, 1'b1, 1'b0, 1'b0);
            if (w) m[sel][idx] = d;
            @(posedge clk); #1;
        end else if (illegal) begin
            @(negedge clk);
            check_all(sel, "illegal_req", 16'h0, 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
            drive(sel, 1'b0, 1'b0, 16'h0, 16'h0);
            @(negedge clk);
            check_all(sel, "illegal_err", 16'h0, 1'b0, 1'b0, 1'b1);
            @(posedge clk); #1;
        end else begin
            @(negedge clk);
            check_all(sel, "no_req", 16'h0, 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_all(0, "idle3", 16'h0, 1'b0, 1'b0, 1'b0);
            check_all(1, "idle1", 16'h0, 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a, d;
        int          sel, kind;

        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_all(0, "reset3", 16'h0, 1'b0, 1'b0, 1'b0);
        check_all(1, "reset1", 16'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(1);

        // Fill both storage images so every later read has a known answer.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 256; i++)
                req(s, 1'b0, 1'b1, 16'(i * 2), 16'($urandom), 1'b0);
            idle(1);
        end

        // Write then read back on LAT=3.
        req(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
        req(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);

        // rd&wr together, then odd address: err pulse, storage untouched.
        req(0, 1'b1, 1'b1, 16'h0004, 16'hDEAD, 1'b0);
        req(0, 1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0);
        req(0, 1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0);
        req(0, 1'b0, 1'b1, 16'h0007, 16'hABCD, 1'b0);

        // Index wraps modulo 256 words.
        req(0, 1'b0, 1'b1, 16'h0202, 16'h1234, 1'b0);
        req(0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0);
        req(0, 1'b1, 1'b0, 16'hFE02, 16'h0000, 1'b0);

        // Reset in the middle of a write aborts it.
        drive(0, 1'b0, 1'b1, 16'h0020, 16'h5555);
        @(negedge clk);
        check_all(0, "rst_accept", 16'h0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check_all(0, "rst_busy", 16'h0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        check_all(0, "rst_after", 16'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        req(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);

        // Inputs changed every BUSY cycle: the captured values commit.
        req(0, 1'b0, 1'b1, 16'h0040, 16'hC0DE, 1'b1);
        req(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1);
        idle(1);

        // LAT=1: back-to-back held requests alternating write/read.
        for (int i = 0; i < 16; i++) begin
            a = 16'($urandom) & 16'hFFFE;
            d = 16'($urandom);
            req(1, 1'b0, 1'b1, a, d, 1'b0);
            req(1, 1'b1, 1'b0, a, 16'h0, 1'b0);
        end
        idle(1);

        // Randomized mix on both instances.
        for (int i = 0; i < 300; i++) begin
            sel  = int'($urandom_range(1, 0));
            kind = int'($urandom_range(7, 0));
            a    = 16'($urandom);
            d    = 16'($urandom);
            if (kind < 6) a[0] = 1'b0;
            if (kind == 7) a[0] = 1'b1;
            if (kind < 3)
                req(sel, 1'b1, 1'b0, a, d, bit'($urandom_range(1, 0)));
            else if (kind < 6)
                req(sel, 1'b0, 1'b1, a, d, bit'($urandom_range(1, 0)));
            else if (kind == 6)
                req(sel, 1'b1, 1'b1, a, d, 1'b0);
            else
                req(sel, bit'($urandom_range(1, 0)), 1'b1, a, d, 1'b0);
            if ($urandom_range(3, 0) == 0) idle(1);
            else begin
                drive(1 - sel, 1'b0, 1'b0, 16'h0, 16'h0);
                idle(0);
            end
            if (sel == 0) drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
            else          drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
            idle(1);
        end

        // Final sweep of a few words on each instance against the model.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++)
                req(s, 1'b1, 1'b0, 16'($urandom) & 16'hFFFE, 16'h0, 1'b0);
            idle(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
